// File: rtl/br_amba_axil_timeout_pkg.sv
// br_amba_axil_timeout_pkg: shared response codes and watchdog state encoding.
package br_amba_axil_timeout_pkg;
    localparam logic [1:0] AxiRespSlverr = 2'b10;
    typedef enum logic [1:0] {NORMAL, FLUSH, ISOLATED} axil_timeout_state_e;
endpackage

// File: rtl/br_amba_axil_timeout_tracker.sv
// br_amba_axil_timeout_tracker: outstanding counter, response timer and NORMAL/FLUSH/ISOLATED sequencing.
module br_amba_axil_timeout_tracker
    import br_amba_axil_timeout_pkg::*;
#(
    parameter int MaxOutstanding = 16,
    parameter int TimeoutCycles = 1024,
    localparam int CntWidth = $clog2(MaxOutstanding + 1),
    localparam int TimerWidth = $clog2(TimeoutCycles)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dn_req_hs,
    input  logic                dn_resp_hs,
    input  logic                up_req_hs,
    input  logic                up_data_hs,
    input  logic                up_resp_hs,
    output axil_timeout_state_e state,
    output logic [CntWidth-1:0] outstanding,
    output logic                req_flag,
    output logic                data_flag,
    output logic                timed_out
);
    logic [TimerWidth-1:0] timer;
    logic expire;
    // A response landing in the final budget cycle beats the timeout.
    assign expire = outstanding != '0 && timer == TimerWidth'(TimeoutCycles - 1) && !dn_resp_hs;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= NORMAL;
            outstanding <= '0;
            timer       <= '0;
            req_flag    <= 1'b0;
            data_flag   <= 1'b0;
            timed_out   <= 1'b0;
        end else begin
            case (state)
                NORMAL: begin
                    outstanding <= outstanding + CntWidth'(dn_req_hs) - CntWidth'(dn_resp_hs);
                    timer       <= (outstanding == '0 || dn_resp_hs) ? '0 : timer + 1'b1;
                    if (expire) begin
                        state     <= FLUSH;
                        timed_out <= 1'b1;
                    end
                end
                FLUSH: begin
                    timer       <= '0;
                    outstanding <= outstanding - CntWidth'(up_resp_hs);
                    if (up_resp_hs && outstanding == CntWidth'(1)) state <= ISOLATED;
                end
                default: begin
                    req_flag  <= up_resp_hs ? 1'b0 : req_flag | up_req_hs;
                    data_flag <= up_resp_hs ? 1'b0 : data_flag | up_data_hs;
                end
            endcase
        end
    end
endmodule

// File: rtl/br_amba_axil_timeout.sv
// br_amba_axil_timeout: AXI4-Lite watchdog that bounds outstanding requests and
// completes everything with SLVERR once the subordinate stops responding.
module br_amba_axil_timeout
    import br_amba_axil_timeout_pkg::*;
#(
    parameter int AddrWidth = 12,
    parameter int DataWidth = 32,
    parameter int ReqUserWidth = 8,
    parameter int ReqDataUserWidth = 8,
    parameter int RespUserWidth = 8,
    parameter int MaxOutstanding = 16,
    parameter int TimeoutCycles = 1024,
    parameter int IsReadNotWrite = 0,
    localparam int CntWidth = $clog2(MaxOutstanding + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [AddrWidth-1:0]        up_req_addr,
    input  logic [2:0]                  up_req_prot,
    input  logic [ReqUserWidth-1:0]     up_req_user,
    input  logic                        up_req_valid,
    output logic                        up_req_ready,
    input  logic [DataWidth-1:0]        up_req_data,
    input  logic [DataWidth/8-1:0]      up_req_data_strb,
    input  logic [ReqDataUserWidth-1:0] up_req_data_user,
    input  logic                        up_req_data_valid,
    output logic                        up_req_data_ready,
    output logic [1:0]                  up_resp_resp,
    output logic [RespUserWidth-1:0]    up_resp_user,
    output logic [DataWidth-1:0]        up_resp_data,
    output logic                        up_resp_valid,
    input  logic                        up_resp_ready,
    output logic [AddrWidth-1:0]        dn_req_addr,
    output logic [2:0]                  dn_req_prot,
    output logic [ReqUserWidth-1:0]     dn_req_user,
    output logic                        dn_req_valid,
    input  logic                        dn_req_ready,
    output logic [DataWidth-1:0]        dn_req_data,
    output logic [DataWidth/8-1:0]      dn_req_data_strb,
    output logic [ReqDataUserWidth-1:0] dn_req_data_user,
    output logic                        dn_req_data_valid,
    input  logic                        dn_req_data_ready,
    input  logic [1:0]                  dn_resp_resp,
    input  logic [RespUserWidth-1:0]    dn_resp_user,
    input  logic [DataWidth-1:0]        dn_resp_data,
    input  logic                        dn_resp_valid,
    output logic                        dn_resp_ready,
    output logic                        timed_out
);
    localparam bit IsWrite = IsReadNotWrite == 0;
    axil_timeout_state_e state;
    logic [CntWidth-1:0] outstanding;
    logic req_flag, data_flag, normal, iso, can_issue;
    assign normal    = state == NORMAL;
    assign iso       = state == ISOLATED;
    assign can_issue = outstanding < CntWidth'(MaxOutstanding);

    assign dn_req_addr       = up_req_addr;
    assign dn_req_prot       = up_req_prot;
    assign dn_req_user       = up_req_user;
    assign dn_req_data       = up_req_data;
    assign dn_req_data_strb  = up_req_data_strb;
    assign dn_req_data_user  = up_req_data_user;
    assign dn_req_valid      = normal && up_req_valid && can_issue;
    assign up_req_ready      = normal ? dn_req_ready && can_issue : iso && !req_flag;
    assign dn_req_data_valid = IsWrite && normal && up_req_data_valid;
    assign up_req_data_ready = IsWrite && (normal ? dn_req_data_ready : iso && !data_flag);
    // Outside NORMAL the subordinate is ignored and every answer is generated locally.
    assign dn_resp_ready = normal ? up_resp_ready : 1'b1;
    assign up_resp_valid = normal ? dn_resp_valid
                         : state == FLUSH || (req_flag && (!IsWrite || data_flag));
    assign up_resp_resp  = normal ? dn_resp_resp : AxiRespSlverr;
    assign up_resp_user  = normal ? dn_resp_user : '0;
    assign up_resp_data  = normal ? dn_resp_data : '0;

    br_amba_axil_timeout_tracker #(
        .MaxOutstanding(MaxOutstanding),
        .TimeoutCycles (TimeoutCycles)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .dn_req_hs  (dn_req_valid && dn_req_ready),
        .dn_resp_hs (dn_resp_valid && dn_resp_ready),
        .up_req_hs  (up_req_valid && up_req_ready),
        .up_data_hs (up_req_data_valid && up_req_data_ready),
        .up_resp_hs (up_resp_valid && up_resp_ready),
        .state      (state),
        .outstanding(outstanding),
        .req_flag   (req_flag),
        .data_flag  (data_flag),
        .timed_out  (timed_out)
    );

    a_up_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        up_req_valid && !up_req_ready |=> up_req_valid);
    a_up_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
        up_req_data_valid && !up_req_data_ready |=> up_req_data_valid);
    a_dn_resp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        dn_resp_valid && !dn_resp_ready |=> dn_resp_valid);
    a_dn_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        dn_req_valid && !dn_req_ready |=> dn_req_valid || timed_out);
    a_dn_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
        dn_req_data_valid && !dn_req_data_ready |=> dn_req_data_valid || timed_out);
    a_up_resp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        up_resp_valid && !up_resp_ready |=> up_resp_valid);
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
        normal && dn_resp_valid |-> outstanding != '0);
    a_outstanding_max: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding <= CntWidth'(MaxOutstanding));
endmodule

// File: tb/tb_br_amba_axil_timeout.sv
// tb_br_amba_axil_timeout: directed checks of passthrough, limit, timeout, race, isolation and async reset.
module tb_br_amba_axil_timeout;
    import br_amba_axil_timeout_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] up_req_addr = '0, dn_req_addr;
    logic [2:0]  up_req_prot = '0, dn_req_prot;
    logic [7:0]  up_req_user = '0, dn_req_user;
    logic        up_req_valid = 1'b0, up_req_ready, dn_req_valid, dn_req_ready = 1'b0;
    logic [31:0] up_req_data = '0, dn_req_data;
    logic [3:0]  up_req_data_strb = '0, dn_req_data_strb;
    logic [7:0]  up_req_data_user = '0, dn_req_data_user;
    logic        up_req_data_valid = 1'b0, up_req_data_ready, dn_req_data_valid, dn_req_data_ready = 1'b0;
    logic [1:0]  up_resp_resp, dn_resp_resp = '0;
    logic [7:0]  up_resp_user, dn_resp_user = '0;
    logic [31:0] up_resp_data, dn_resp_data = '0;
    logic        up_resp_valid, up_resp_ready = 1'b0, dn_resp_valid = 1'b0, dn_resp_ready;
    logic        timed_out;
    int n_cmp = 0;
    int n_err = 0;

    br_amba_axil_timeout #(
        .MaxOutstanding(2),
        .TimeoutCycles (8),
        .IsReadNotWrite(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .up_req_addr(up_req_addr), .up_req_prot(up_req_prot), .up_req_user(up_req_user),
        .up_req_valid(up_req_valid), .up_req_ready(up_req_ready),
        .up_req_data(up_req_data), .up_req_data_strb(up_req_data_strb), .up_req_data_user(up_req_data_user),
        .up_req_data_valid(up_req_data_valid), .up_req_data_ready(up_req_data_ready),
        .up_resp_resp(up_resp_resp), .up_resp_user(up_resp_user), .up_resp_data(up_resp_data),
        .up_resp_valid(up_resp_valid), .up_resp_ready(up_resp_ready),
        .dn_req_addr(dn_req_addr), .dn_req_prot(dn_req_prot), .dn_req_user(dn_req_user),
        .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready),
        .dn_req_data(dn_req_data), .dn_req_data_strb(dn_req_data_strb), .dn_req_data_user(dn_req_data_user),
        .dn_req_data_valid(dn_req_data_valid), .dn_req_data_ready(dn_req_data_ready),
        .dn_resp_resp(dn_resp_resp), .dn_resp_user(dn_resp_user), .dn_resp_data(dn_resp_data),
        .dn_resp_valid(dn_resp_valid), .dn_resp_ready(dn_resp_ready),
        .timed_out(timed_out)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (up_resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_up_resp_valid: got %b want 0", up_resp_valid); end
        n_cmp++; if (dn_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_dn_req_valid: got %b want 0", dn_req_valid); end
        n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL reset_timed_out: got %b want 0", timed_out); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (u_dut.u_tracker.state !== NORMAL) begin n_err++; $display("FAIL reset_state: got %0d want NORMAL", u_dut.u_tracker.state); end
    endtask

    task automatic test_passthrough();
        dn_req_ready = 1'b1; dn_req_data_ready = 1'b1; up_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            up_req_addr = 12'h100 + 12'(4 * i); up_req_valid = 1'b1;
            up_req_data = 32'hA000_0000 + i; up_req_data_strb = 4'hF; up_req_data_valid = 1'b1;
            @(negedge clk);
            n_cmp++; if (dn_req_valid !== 1'b1 || dn_req_addr !== 12'h100 + 12'(4 * i)) begin n_err++; $display("FAIL pass_req%0d: got v=%b a=%0h want v=1 a=%0h", i, dn_req_valid, dn_req_addr, 12'h100 + 12'(4 * i)); end
            n_cmp++; if (dn_req_data_valid !== 1'b1 || dn_req_data !== 32'hA000_0000 + i) begin n_err++; $display("FAIL pass_data%0d: got v=%b d=%0h", i, dn_req_data_valid, dn_req_data); end
            @(posedge clk); #1 up_req_valid = 1'b0; up_req_data_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1 dn_resp_valid = 1'b1; dn_resp_resp = 2'b00; dn_resp_data = 32'h5000 + i; dn_resp_user = 8'(i + 1);
            @(negedge clk);
            n_cmp++; if (up_resp_valid !== 1'b1 || up_resp_resp !== 2'b00 || up_resp_data !== 32'h5000 + i || up_resp_user !== 8'(i + 1)) begin n_err++; $display("FAIL pass_resp%0d: got v=%b r=%0h d=%0h u=%0h", i, up_resp_valid, up_resp_resp, up_resp_data, up_resp_user); end
            @(posedge clk); #1 dn_resp_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL pass_timed_out: got %b want 0", timed_out); end
        n_cmp++; if (u_dut.u_tracker.outstanding !== 2'd0) begin n_err++; $display("FAIL pass_outstanding: got %0d want 0", u_dut.u_tracker.outstanding); end
    endtask

    task automatic test_limit();
        @(posedge clk); #1 up_req_valid = 1'b1; up_req_addr = 12'h010;
        @(posedge clk); #1 up_req_addr = 12'h014;
        @(posedge clk); #1 up_req_addr = 12'h018;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (dn_req_valid !== 1'b0 || up_req_ready !== 1'b0) begin n_err++; $display("FAIL limit_block%0d: got dn_v=%b up_rdy=%b want 0 0", i, dn_req_valid, up_req_ready); end
            @(posedge clk);
        end
        #1 dn_resp_valid = 1'b1; dn_resp_resp = 2'b00;
        @(negedge clk);
        n_cmp++; if (up_req_ready !== 1'b0 || up_resp_valid !== 1'b1) begin n_err++; $display("FAIL limit_no_bypass: got up_rdy=%b resp_v=%b want 0 1", up_req_ready, up_resp_valid); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (dn_req_valid !== 1'b1 || up_req_ready !== 1'b1 || dn_req_addr !== 12'h018) begin n_err++; $display("FAIL limit_release: got v=%b rdy=%b a=%0h want 1 1 18", dn_req_valid, up_req_ready, dn_req_addr); end
        @(posedge clk); #1 up_req_valid = 1'b0;
        @(posedge clk); #1 dn_resp_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (u_dut.u_tracker.outstanding !== 2'd0 || timed_out !== 1'b0) begin n_err++; $display("FAIL limit_drain: got out=%0d to=%b want 0 0", u_dut.u_tracker.outstanding, timed_out); end
    endtask

    task automatic test_race();
        @(posedge clk); #1 up_req_valid = 1'b1; up_req_addr = 12'h020;
        @(posedge clk); #1 up_req_addr = 12'h024;
        @(posedge clk); #1 up_req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 dn_resp_valid = 1'b1; dn_resp_resp = 2'b00; dn_resp_data = 32'h77; up_resp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (u_dut.u_tracker.timer !== 3'd7) begin n_err++; $display("FAIL race_timer_at_edge: got %0d want 7", u_dut.u_tracker.timer); end
        n_cmp++; if (up_resp_valid !== 1'b1 || up_resp_resp !== 2'b00 || up_resp_data !== 32'h77) begin n_err++; $display("FAIL race_okay_fwd: got v=%b r=%0h d=%0h", up_resp_valid, up_resp_resp, up_resp_data); end
        @(posedge clk); #1 dn_resp_valid = 1'b0; up_resp_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (timed_out !== 1'b0 || u_dut.u_tracker.timer !== 3'd0) begin n_err++; $display("FAIL race_no_timeout: got to=%b timer=%0d want 0 0", timed_out, u_dut.u_tracker.timer); end
        repeat (7) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL race_second_early: got %b want 0", timed_out); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (timed_out !== 1'b1 || up_resp_valid !== 1'b1 || up_resp_resp !== AxiRespSlverr) begin n_err++; $display("FAIL race_second_timeout: got to=%b v=%b r=%0h want 1 1 2", timed_out, up_resp_valid, up_resp_resp); end
    endtask

    task automatic test_async_reset_flush();
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (up_resp_valid !== 1'b0 || dn_req_valid !== 1'b0 || timed_out !== 1'b0) begin n_err++; $display("FAIL async_rst_outputs: got rv=%b dv=%b to=%b want 0 0 0", up_resp_valid, dn_req_valid, timed_out); end
        n_cmp++; if (u_dut.u_tracker.state !== NORMAL || u_dut.u_tracker.outstanding !== 2'd0) begin n_err++; $display("FAIL async_rst_state: got st=%0d out=%0d want NORMAL 0", u_dut.u_tracker.state, u_dut.u_tracker.outstanding); end
        @(posedge clk); #2 rst_n = 1'b1;
        up_req_valid = 1'b1; up_req_addr = 12'h030;
        @(negedge clk);
        n_cmp++; if (dn_req_valid !== 1'b1 || up_req_ready !== 1'b1) begin n_err++; $display("FAIL async_rst_normal: got v=%b rdy=%b want 1 1", dn_req_valid, up_req_ready); end
        @(posedge clk); #1 up_req_valid = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        dn_resp_data = 32'hDEAD_BEEF; dn_resp_user = 8'h5A; up_resp_ready = 1'b0;
        up_req_valid = 1'b1; up_req_addr = 12'h040;
        @(posedge clk); #1 up_req_addr = 12'h044;
        @(posedge clk); #1 up_req_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL to_early: got %b want 0", timed_out); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (timed_out !== 1'b1) begin n_err++; $display("FAIL to_rise: got %b want 1", timed_out); end
        n_cmp++; if (up_resp_valid !== 1'b1 || up_resp_resp !== 2'b10 || up_resp_data !== 32'h0 || up_resp_user !== 8'h0) begin n_err++; $display("FAIL to_flush_resp: got v=%b r=%0h d=%0h u=%0h want 1 2 0 0", up_resp_valid, up_resp_resp, up_resp_data, up_resp_user); end
        n_cmp++; if (dn_resp_ready !== 1'b1 || up_req_ready !== 1'b0) begin n_err++; $display("FAIL to_flush_ready: got dn_rdy=%b up_rdy=%b want 1 0", dn_resp_ready, up_req_ready); end
        up_resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (up_resp_valid !== 1'b1 || up_resp_resp !== 2'b10) begin n_err++; $display("FAIL to_second_err: got v=%b r=%0h want 1 2", up_resp_valid, up_resp_resp); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (up_resp_valid !== 1'b0 || u_dut.u_tracker.state !== ISOLATED) begin n_err++; $display("FAIL to_isolated: got v=%b st=%0d want 0 ISOLATED", up_resp_valid, u_dut.u_tracker.state); end
        up_resp_ready = 1'b0;
    endtask

    task automatic test_isolated_write();
        @(posedge clk); #1 up_req_valid = 1'b1; up_req_addr = 12'h200;
        @(negedge clk);
        n_cmp++; if (up_req_ready !== 1'b1 || dn_req_valid !== 1'b0) begin n_err++; $display("FAIL iso_aw: got rdy=%b dv=%b want 1 0", up_req_ready, dn_req_valid); end
        @(posedge clk); #1 up_req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (up_req_ready !== 1'b0 || up_resp_valid !== 1'b0) begin n_err++; $display("FAIL iso_aw_held: got rdy=%b rv=%b want 0 0", up_req_ready, up_resp_valid); end
        @(posedge clk);
        @(posedge clk); #1 up_req_data_valid = 1'b1; up_req_data = 32'h0000_DEAD;
        @(negedge clk);
        n_cmp++; if (up_req_data_ready !== 1'b1 || dn_req_data_valid !== 1'b0 || up_resp_valid !== 1'b0) begin n_err++; $display("FAIL iso_w: got wr=%b dwv=%b rv=%b want 1 0 0", up_req_data_ready, dn_req_data_valid, up_resp_valid); end
        @(posedge clk); #1 up_req_data_valid = 1'b0; up_resp_ready = 1'b1; dn_resp_valid = 1'b1; dn_resp_resp = 2'b00;
        @(negedge clk);
        n_cmp++; if (up_resp_valid !== 1'b1 || up_resp_resp !== 2'b10 || up_resp_data !== 32'h0) begin n_err++; $display("FAIL iso_resp: got v=%b r=%0h d=%0h want 1 2 0", up_resp_valid, up_resp_resp, up_resp_data); end
        n_cmp++; if (dn_resp_ready !== 1'b1) begin n_err++; $display("FAIL iso_drop_ready: got %b want 1", dn_resp_ready); end
        @(posedge clk); #1 dn_resp_valid = 1'b0; up_resp_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (up_resp_valid !== 1'b0 || timed_out !== 1'b1 || dn_req_valid !== 1'b0) begin n_err++; $display("FAIL iso_done: got rv=%b to=%b dv=%b want 0 1 0", up_resp_valid, timed_out, dn_req_valid); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_limit();
        test_race();
        test_async_reset_flush();
        test_timeout();
        test_isolated_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
